// File: rtl/vector_mem_arbiter.sv
// vector_mem_arbiter
//
// Two-port arbiter and sequencer in front of the single-port vector data
// memory (combinational read, synchronous write). Port 0 is the vector
// load/store unit, port 1 the program/data loader. At most one access is
// granted per cycle. Arbitration is round-robin with a bounded burst: the
// last-granted port keeps the memory for up to MAX_BURST consecutive grants
// while the other port is waiting.
//
// Optional feature macro: VMEM_ARB_BOUNDS_CHECK_EN
//   defined   : accesses with addr >= MEM_SIZE are blocked (no write, reads
//               return 0) and flag err0/err1 one cycle after the grant.
//   undefined : no range check, err0/err1 are constant 0.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*    requester ports 0 and 1
//   gnt*                     combinational grant; access completes at the
//                            rising edge where req and gnt are both high
//   rvalid*/rdata*           registered read data, one-cycle valid pulse
//   err*                     out-of-range pulse (bounds check builds only)
//   mem_*                    single-port memory interface
module vector_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 19,
    parameter int DATA_WIDTH    = 64,
    parameter int MEM_SIZE      = 500,
    parameter int MAX_BURST     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata0,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic                     err0,
    output logic                     err1,
    output logic                     mem_writeEnable,
    output logic [ADDRESS_WIDTH-1:0] mem_readAddress,
    output logic [ADDRESS_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0]    mem_inputData,
    input  logic [DATA_WIDTH-1:0]    mem_outputData
);

    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);

    logic [1:0]               req;
    logic [1:0]               we;
    logic [1:0]               gnt;
    logic [ADDRESS_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0]    wdata [2];

    logic          owner_reg;
    logic [BW-1:0] burst_cnt_reg;
    logic          any_gnt;
    logic          sel;
    logic          in_range;

    assign req      = {req1, req0};
    assign we       = {we1, we0};
    assign addr[0]  = addr0;
    assign addr[1]  = addr1;
    assign wdata[0] = wdata0;
    assign wdata[1] = wdata1;

    // Grant decision. While reset is asserted nothing is granted, which also
    // keeps a write presented during reset from reaching the memory.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (burst_cnt_reg < BURST_MAX)
                        gnt = owner_reg ? 2'b10 : 2'b01;
                    else
                        gnt = owner_reg ? 2'b01 : 2'b10;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign any_gnt = |gnt;
    // Port 1 only when it holds the grant; port 0 otherwise, which also makes
    // port 0's address the idle value on the memory bus.
    assign sel     = gnt[1];

`ifdef VMEM_ARB_BOUNDS_CHECK_EN
    localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_SIZE);
    assign in_range = ({1'b0, addr[sel]} < MEM_LIMIT);
`else
    assign in_range = 1'b1;
`endif

    assign mem_readAddress  = addr[sel];
    assign mem_writeAddress = addr[sel];
    assign mem_inputData    = wdata[sel];
    assign mem_writeEnable  = any_gnt & we[sel] & in_range;

    // Arbitration state. The counter saturates so a long uncontested run
    // hands over immediately once the other port starts requesting; an idle
    // cycle clears it so the next contender starts a fresh burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg     <= 1'b0;
            burst_cnt_reg <= '0;
        end else if (any_gnt) begin
            if (sel == owner_reg) begin
                if (burst_cnt_reg < BURST_MAX)
                    burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end else begin
                owner_reg     <= sel;
                burst_cnt_reg <= BW'(1);
            end
        end else begin
            burst_cnt_reg <= '0;
        end
    end

    // Per-port response registers. rdata only updates on that port's own
    // granted read, so the other port's data holds.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic                  rvalid_reg;
            logic                  err_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rvalid_reg <= 1'b0;
                    err_reg    <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= gnt[gi] & ~we[gi];
                    err_reg    <= gnt[gi] & ~in_range;
                    if (gnt[gi] & ~we[gi])
                        rdata_reg <= in_range ? mem_outputData : '0;
                end
            end
        end
    endgenerate

    assign rvalid0 = g_port[0].rvalid_reg;
    assign rvalid1 = g_port[1].rvalid_reg;
    assign rdata0  = g_port[0].rdata_reg;
    assign rdata1  = g_port[1].rdata_reg;

`ifdef VMEM_ARB_BOUNDS_CHECK_EN
    assign err0 = g_port[0].err_reg;
    assign err1 = g_port[1].err_reg;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Testbench for vector_mem_arbiter: drives both requester ports, models the
// attached memory, and predicts grants, memory controls and read responses
// from the arbitration rules (run-length of the last owner, round-robin
// hand-over, idle reset of the run).
module tb_vector_mem_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 64;
    localparam int MSZ   = 500;
    localparam int MB    = 4;
    localparam int DEPTH = 1024;
`ifdef VMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_ON = 1'b1;
`else
    localparam bit BOUNDS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_writeEnable;
    logic [AW-1:0] mem_readAddress, mem_writeAddress;
    logic [DW-1:0] mem_inputData, mem_outputData;

    vector_mem_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MSZ), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_writeEnable(mem_writeEnable), .mem_readAddress(mem_readAddress),
        .mem_writeAddress(mem_writeAddress), .mem_inputData(mem_inputData),
        .mem_outputData(mem_outputData)
    );

    // Memory attached to the DUT, with a preload path for initial contents.
    logic [DW-1:0] tb_mem [DEPTH];
    logic          pl_en;
    logic [9:0]    pl_addr;
    logic [DW-1:0] pl_data;
    always_ff @(posedge clk) begin
        if (pl_en)
            tb_mem[pl_addr] <= pl_data;
        else if (mem_writeEnable)
            tb_mem[mem_writeAddress[9:0]] <= mem_inputData;
    end
    assign mem_outputData = tb_mem[mem_readAddress[9:0]];

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_owner;
    int            m_streak;
    logic [1:0]    exp_gnt;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_rv;
    logic [1:0]    exp_err;
    logic [DW-1:0] exp_rd [2];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return !BOUNDS_ON || (int'(a) < MSZ);
    endfunction

    function automatic logic [1:0] model_grant();
        if (!rst) return 2'b00;
        if (req0 && !req1) return 2'b01;
        if (req1 && !req0) return 2'b10;
        if (!req0 && !req1) return 2'b00;
        if (m_streak < MB) return (m_owner == 0) ? 2'b01 : 2'b10;
        return (m_owner == 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic void predict();
        logic p1;
        exp_gnt  = model_grant();
        p1       = exp_gnt[1];
        exp_addr = p1 ? addr1 : addr0;
        exp_we   = (exp_gnt != 2'b00) && (p1 ? we1 : we0) && in_rng(exp_addr);
    endfunction

    function automatic void model_reset();
        m_owner   = 0;
        m_streak  = 0;
        exp_rv    = 2'b00;
        exp_err   = 2'b00;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endfunction

    // Apply the predicted grant to the model: run length, memory contents and
    // the registered responses expected after the coming edge.
    task automatic commit();
        int            p;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        exp_rv  = 2'b00;
        exp_err = 2'b00;
        if (exp_gnt == 2'b00) begin
            m_streak = 0;
            return;
        end
        p = exp_gnt[1] ? 1 : 0;
        a = p ? addr1 : addr0;
        w = p ? we1 : we0;
        d = p ? wdata1 : wdata0;
        if (p == m_owner) m_streak++;
        else begin
            m_owner  = p;
            m_streak = 1;
        end
        if (w) begin
            if (in_rng(a)) ref_mem[a[9:0]] = d;
        end else begin
            exp_rv[p] = 1'b1;
            exp_rd[p] = in_rng(a) ? ref_mem[a[9:0]] : '0;
        end
        exp_err[p] = !in_rng(a);
        $display("txn port%0d %s addr=%0d data=%h", p, w ? "WR" : "RD", a, w ? d : exp_rd[p]);
    endtask

    task automatic step(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        predict();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 10'(i);
            pl_data = {$urandom, $urandom};
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({gnt1, gnt0, rvalid1, rvalid0, err1, err0, mem_writeEnable} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {gnt1, gnt0, rvalid1, rvalid0, err1, err0, mem_writeEnable});
        end
        n_cmp++;
        if (rdata0 !== '0 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b0, AW'(3), '0, 1'b1, 1'b0, AW'(4), '0);
            n_cmp++;
            if ({gnt1, gnt0} !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_first_gnt: got %b expected 01", {gnt1, gnt0});
            end
            commit();
        end
        // Reset mid-burst while port 0 presents a write
        @(negedge clk);
        rst = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = AW'(9); wdata0 = ~ref_mem[9];
        req1 = 1'b1; we1 = 1'b0;
        #1;
        n_cmp++;
        if ({gnt1, gnt0, rvalid1, rvalid0, err1, err0, mem_writeEnable} !== 7'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got %b expected 0000000",
                     {gnt1, gnt0, rvalid1, rvalid0, err1, err0, mem_writeEnable});
        end
        n_cmp++;
        if (rdata0 !== '0 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL midreset_rdata: got %h/%h expected 0/0", rdata0, rdata1);
        end
        model_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if (tb_mem[9] !== ref_mem[9]) begin
            n_fail++;
            $display("FAIL midreset_write_blocked: got %h expected %h", tb_mem[9], ref_mem[9]);
        end
        rst = 1'b1; we0 = 1'b0; addr0 = AW'(3); wdata0 = '0;
        #1;
        predict();
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_fail++;
            $display("FAIL release_first_gnt: got %b expected 01", {gnt1, gnt0});
        end
        commit();
    endtask

    task automatic test_contention();
        logic [1:0]    seq [12];
        logic [AW-1:0] a0, a1;
        for (int c = 0; c < 12; c++) seq[c] = ((c / MB) % 2 == 1) ? 2'b10 : 2'b01;
        a0 = AW'($urandom_range(0, MSZ - 1));
        a1 = AW'($urandom_range(0, MSZ - 1));
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, a0, '0, 1'b1, 1'b0, a1, '0);
            n_cmp++;
            if ({gnt1, gnt0} !== seq[c]) begin
                n_fail++;
                $display("FAIL contention_gnt[%0d]: got %b expected %b", c, {gnt1, gnt0}, seq[c]);
            end
            if (c > 0) begin
                n_cmp++;
                if ({rvalid1, rvalid0} !== seq[c-1]) begin
                    n_fail++;
                    $display("FAIL contention_rvalid[%0d]: got %b expected %b",
                             c, {rvalid1, rvalid0}, seq[c-1]);
                end
                n_cmp++;
                if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
                    n_fail++;
                    $display("FAIL contention_rdata[%0d]: got %h/%h expected %h/%h",
                             c, rdata0, rdata1, exp_rd[0], exp_rd[1]);
                end
            end
            commit();
        end
    endtask

    task automatic test_single_requester();
        logic [AW-1:0] a1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            a1 = AW'($urandom_range(0, MSZ - 1));
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, a1, '0);
            n_cmp++;
            if ({gnt1, gnt0} !== 2'b10) begin
                n_fail++;
                $display("FAIL single_gnt1[%0d]: got %b expected 10", c, {gnt1, gnt0});
            end
            commit();
        end
        step(1'b1, 1'b0, AW'(5), '0, 1'b1, 1'b0, AW'(6), '0);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_handover: got %b expected 01", {gnt1, gnt0});
        end
        commit();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] wval;
        wval = 64'h0123456789ABCDEF;
        do_reset();
        step(1'b1, 1'b1, AW'(7), wval, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (mem_writeEnable !== 1'b1 || mem_writeAddress !== AW'(7) || mem_inputData !== wval) begin
            n_fail++;
            $display("FAIL wr_mem_side: got we=%b addr=%0d data=%h expected we=1 addr=7 data=%h",
                     mem_writeEnable, mem_writeAddress, mem_inputData, wval);
        end
        commit();
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(7), '0);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b10 || mem_readAddress !== AW'(7)) begin
            n_fail++;
            $display("FAIL rd_grant: got gnt=%b raddr=%0d expected gnt=10 raddr=7",
                     {gnt1, gnt0}, mem_readAddress);
        end
        commit();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== wval) begin
            n_fail++;
            $display("FAIL rd_data: got rvalid=%b%b rdata1=%h expected rvalid=10 rdata1=%h",
                     rvalid1, rvalid0, rdata1, wval);
        end
        commit();
    endtask

    task automatic test_idle_burst();
        logic [1:0] seq [6];
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, AW'(c), '0, 1'b0, 1'b0, '0, '0);
            commit();
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_gnt: got %b expected 00", {gnt1, gnt0});
        end
        commit();
        for (int c = 0; c < 6; c++) seq[c] = (c < MB) ? 2'b01 : 2'b10;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b0, AW'(10), '0, 1'b1, 1'b0, AW'(11), '0);
            n_cmp++;
            if ({gnt1, gnt0} !== seq[c]) begin
                n_fail++;
                $display("FAIL idle_burst_gnt[%0d]: got %b expected %b", c, {gnt1, gnt0}, seq[c]);
            end
            commit();
        end
    endtask

    task automatic test_bounds();
        logic [DW-1:0] rd600;
        do_reset();
        step(1'b1, 1'b1, AW'(500), 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (gnt0 !== 1'b1 || mem_writeEnable !== !BOUNDS_ON) begin
            n_fail++;
            $display("FAIL bounds_wr_en: got gnt0=%b we=%b expected gnt0=1 we=%b",
                     gnt0, mem_writeEnable, !BOUNDS_ON);
        end
        commit();
        rd600 = BOUNDS_ON ? '0 : ref_mem[600];
        step(1'b1, 1'b0, AW'(600), '0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (err0 !== BOUNDS_ON || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_wr_err: got err0=%b rvalid0=%b expected err0=%b rvalid0=0",
                     err0, rvalid0, BOUNDS_ON);
        end
        commit();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (err0 !== BOUNDS_ON || rvalid0 !== 1'b1 || rdata0 !== rd600) begin
            n_fail++;
            $display("FAIL bounds_rd: got err0=%b rvalid0=%b rdata0=%h expected err0=%b rvalid0=1 rdata0=%h",
                     err0, rvalid0, rdata0, BOUNDS_ON, rd600);
        end
        commit();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (err0 !== 1'b0 || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_pulse_end: got err0=%b rvalid0=%b expected 0/0", err0, rvalid0);
        end
        commit();
    endtask

    task automatic test_random();
        logic          pend0, pend1, r0, r1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        pend0 = 1'b0; pend1 = 1'b0;
        r0 = 1'b0; r1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            // An ungranted request is held stable until it is granted.
            if (!pend0) begin
                r0 = ($urandom_range(0, 2) != 0);
                w0 = $urandom_range(0, 1) == 1;
                a0 = AW'($urandom_range(0, DEPTH - 1));
                d0 = {$urandom, $urandom};
            end
            if (!pend1) begin
                r1 = ($urandom_range(0, 2) != 0);
                w1 = $urandom_range(0, 1) == 1;
                a1 = AW'($urandom_range(0, DEPTH - 1));
                d1 = {$urandom, $urandom};
            end
            step(r0, w0, a0, d0, r1, w1, a1, d1);
            n_cmp++;
            if ({gnt1, gnt0} !== exp_gnt || mem_writeEnable !== exp_we) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got gnt=%b we=%b expected gnt=%b we=%b",
                         c, {gnt1, gnt0}, mem_writeEnable, exp_gnt, exp_we);
            end
            n_cmp++;
            if (mem_readAddress !== exp_addr || mem_writeAddress !== exp_addr) begin
                n_fail++;
                $display("FAIL rand_addr[%0d]: got r=%0d w=%0d expected %0d",
                         c, mem_readAddress, mem_writeAddress, exp_addr);
            end
            n_cmp++;
            if ({rvalid1, rvalid0} !== exp_rv || {err1, err0} !== exp_err) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: got rvalid=%b err=%b expected rvalid=%b err=%b",
                         c, {rvalid1, rvalid0}, {err1, err0}, exp_rv, exp_err);
            end
            n_cmp++;
            if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
                n_fail++;
                $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h",
                         c, rdata0, rdata1, exp_rd[0], exp_rd[1]);
            end
            if (exp_gnt != 2'b00) begin
                n_cmp++;
                if (mem_inputData !== (exp_gnt[1] ? d1 : d0)) begin
                    n_fail++;
                    $display("FAIL rand_wdata[%0d]: got %h expected %h",
                             c, mem_inputData, exp_gnt[1] ? d1 : d0);
                end
            end
            pend0 = r0 && !exp_gnt[0];
            pend1 = r1 && !exp_gnt[1];
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_requester();
        test_write_read();
        test_idle_burst();
        test_bounds();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
